// File: rtl/issue_hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : issue_hazard_pkg
//  Description : Shared core definitions for the issue/hazard slice: register
//                file geometry, scoreboard pending-count vector type and the
//                issue FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package issue_hazard_pkg;

  localparam int NREG   = 8;   // architectural registers, all tracked alike
  localparam int RA_W   = 3;   // register-address width
  localparam int PEND_W = 3;   // per-register pending-writeback count width

  typedef logic [RA_W-1:0]               reg_adr_t;
  typedef logic [NREG-1:0][PEND_W-1:0]   pend_vec_t;

  // Issue FSM state encoding
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

endpackage : issue_hazard_pkg
`default_nettype wire

// File: rtl/issue_hazard_if.sv
`default_nettype none
// ============================================================================
//  Module      : issue_hazard_if
//  Description : Bundle between the decode stage / scoreboard (master) and the
//                hazard unit (slave).
//    master drives : id_valid, id_rs_adr, id_rt_adr, id_rs_use, id_rt_use,
//                    id_regwrite, id_wr_adr, id_is_load, flush,
//                    register_invalid
//    slave drives  : stall, regwrite_cur, from_main_mem, regwrite_adr_id,
//                    stall_cycles, hang
//  Revision    : 1.0 - initial release
// ============================================================================
interface issue_hazard_if
  import issue_hazard_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic             id_valid;
  reg_adr_t         id_rs_adr;
  reg_adr_t         id_rt_adr;
  logic             id_rs_use;
  logic             id_rt_use;
  logic             id_regwrite;
  reg_adr_t         id_wr_adr;
  logic             id_is_load;
  logic             flush;
  pend_vec_t        register_invalid;

  logic             stall;
  logic             regwrite_cur;
  logic             from_main_mem;
  reg_adr_t         regwrite_adr_id;
  logic [CNT_W-1:0] stall_cycles;
  logic             hang;

  modport master (
    output id_valid, id_rs_adr, id_rt_adr, id_rs_use, id_rt_use,
           id_regwrite, id_wr_adr, id_is_load, flush, register_invalid,
    input  stall, regwrite_cur, from_main_mem, regwrite_adr_id,
           stall_cycles, hang
  );

  modport slave (
    input  id_valid, id_rs_adr, id_rt_adr, id_rs_use, id_rt_use,
           id_regwrite, id_wr_adr, id_is_load, flush, register_invalid,
    output stall, regwrite_cur, from_main_mem, regwrite_adr_id,
           stall_cycles, hang
  );

endinterface : issue_hazard_if
`default_nettype wire

// File: rtl/issue_hazard_src_hazard.sv
`default_nettype none
// ============================================================================
//  Module      : src_hazard
//  Description : Checks one register number of the ID instruction against the
//                scoreboard pending counts and the claim issued last cycle.
//    use_i              : this register number is actually referenced
//    adr_i              : register number
//    register_invalid_i : per-register pending-writeback counts
//    claim_vld_i        : a destination claim is in flight this cycle
//    claim_adr_i        : register number of that claim
//    hazard_o           : register is busy
//  Revision    : 1.0 - initial release
// ============================================================================
module src_hazard
  import issue_hazard_pkg::*;
(
  input  wire logic      use_i,
  input  wire reg_adr_t  adr_i,
  input  wire pend_vec_t register_invalid_i,
  input  wire logic      claim_vld_i,
  input  wire reg_adr_t  claim_adr_i,
  output logic           hazard_o
);

  logic w_pending;
  logic w_inflight;

  assign w_pending  = (register_invalid_i[adr_i] != '0);
  // The scoreboard only sees a claim one cycle late, so cover that gap here.
  assign w_inflight = claim_vld_i & (adr_i == claim_adr_i);
  assign hazard_o   = use_i & (w_pending | w_inflight);

endmodule : src_hazard
`default_nettype wire

// File: rtl/issue_hazard.sv
`default_nettype none
// ============================================================================
//  Module      : issue_hazard
//  Description : ID-stage issue/hazard unit. Stalls the front end while any
//                referenced register is pending, registers the destination
//                claim of each issued writer, counts stalled cycles and flags
//                a sticky hang after MAX_STALL consecutive stall cycles.
//    clk   : clock, rising edge
//    reset : asynchronous, active-low
//    bus   : issue_hazard_if.slave (decode inputs, hazard/claim outputs)
//  Revision    : 1.0 - initial release
// ============================================================================
module issue_hazard
  import issue_hazard_pkg::*;
#(
  parameter int MAX_STALL = 16,
  parameter int CNT_W     = 16
)(
  input  wire logic clk,
  input  wire logic reset,
  issue_hazard_if.slave bus
);

  localparam int CONS_W = $clog2(MAX_STALL + 1);

  logic              w_haz_rs, w_haz_rt, w_haz_wr;
  logic              w_hazard, w_stall, w_issue;

  logic [0:0]        state_q, state_d;
  logic              regwrite_cur_q, regwrite_cur_d;
  logic              from_main_mem_q, from_main_mem_d;
  reg_adr_t          regwrite_adr_q, regwrite_adr_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [CONS_W-1:0] consec_q, consec_d;
  logic              hang_q, hang_d;

  src_hazard u_rs (
    .use_i              (bus.id_rs_use),
    .adr_i              (bus.id_rs_adr),
    .register_invalid_i (bus.register_invalid),
    .claim_vld_i        (regwrite_cur_q),
    .claim_adr_i        (regwrite_adr_q),
    .hazard_o           (w_haz_rs)
  );

  src_hazard u_rt (
    .use_i              (bus.id_rt_use),
    .adr_i              (bus.id_rt_adr),
    .register_invalid_i (bus.register_invalid),
    .claim_vld_i        (regwrite_cur_q),
    .claim_adr_i        (regwrite_adr_q),
    .hazard_o           (w_haz_rt)
  );

  // Destination check avoids write-after-write reordering with a pending write.
  src_hazard u_wr (
    .use_i              (bus.id_regwrite),
    .adr_i              (bus.id_wr_adr),
    .register_invalid_i (bus.register_invalid),
    .claim_vld_i        (regwrite_cur_q),
    .claim_adr_i        (regwrite_adr_q),
    .hazard_o           (w_haz_wr)
  );

  assign w_hazard = bus.id_valid & (w_haz_rs | w_haz_rt | w_haz_wr);
  // Flush kills the ID instruction, so it can neither stall nor issue.
  assign w_stall  = w_hazard & ~bus.flush;
  assign w_issue  = bus.id_valid & ~w_hazard & ~bus.flush;

  always_comb begin
    regwrite_cur_d  = w_issue & bus.id_regwrite;
    regwrite_adr_d  = regwrite_adr_q;
    from_main_mem_d = from_main_mem_q;
    if (w_issue && bus.id_regwrite) begin
      regwrite_adr_d  = bus.id_wr_adr;
      from_main_mem_d = bus.id_is_load;
    end

    // w_stall is already low under flush, so flush lands in RUN.
    state_d = w_stall ? ST_STALL : ST_RUN;

    stall_cycles_d = stall_cycles_q;
    if (w_stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end

    // consec_q holds the number of stall cycles already completed in this
    // run; hang sets at the close of the MAX_STALL-th one.
    consec_d = '0;
    hang_d   = hang_q;
    if (w_stall) begin
      consec_d = (consec_q == CONS_W'(MAX_STALL)) ? consec_q : consec_q + 1'b1;
      if (consec_q >= CONS_W'(MAX_STALL - 1)) begin
        hang_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_RUN;
      regwrite_cur_q  <= 1'b0;
      from_main_mem_q <= 1'b0;
      regwrite_adr_q  <= '0;
      stall_cycles_q  <= '0;
      consec_q        <= '0;
      hang_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      regwrite_cur_q  <= regwrite_cur_d;
      from_main_mem_q <= from_main_mem_d;
      regwrite_adr_q  <= regwrite_adr_d;
      stall_cycles_q  <= stall_cycles_d;
      consec_q        <= consec_d;
      hang_q          <= hang_d;
    end
  end

  assign bus.stall           = w_stall;
  assign bus.regwrite_cur    = regwrite_cur_q;
  assign bus.from_main_mem   = from_main_mem_q;
  assign bus.regwrite_adr_id = regwrite_adr_q;
  assign bus.stall_cycles    = stall_cycles_q;
  assign bus.hang            = hang_q;

endmodule : issue_hazard
`default_nettype wire

// File: tb/tb_issue_hazard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_issue_hazard
//  Description : Directed self-checking bench for issue_hazard (CNT_W=4,
//                MAX_STALL=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_hazard;
  import issue_hazard_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  issue_hazard_if #(.CNT_W(4)) bus ();

  issue_hazard #(.MAX_STALL(16), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.id_valid         = 1'b0;
    bus.id_rs_adr        = '0;
    bus.id_rt_adr        = '0;
    bus.id_rs_use        = 1'b0;
    bus.id_rt_use        = 1'b0;
    bus.id_regwrite      = 1'b0;
    bus.id_wr_adr        = '0;
    bus.id_is_load       = 1'b0;
    bus.flush            = 1'b0;
    bus.register_invalid = '0;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    repeat (2) tick();
    chk("rst_cur",   bus.regwrite_cur, 0);
    chk("rst_fmm",   bus.from_main_mem, 0);
    chk("rst_adr",   bus.regwrite_adr_id, 0);
    chk("rst_cnt",   bus.stall_cycles, 0);
    chk("rst_hang",  bus.hang, 0);
    chk("rst_state", dut.state_q, ST_RUN);
    reset = 1'b1;
    #1 chk("post_rst_cur", bus.regwrite_cur, 0);

    // Pending count on r3 decays 2 -> 1 -> 0
    bus.id_valid = 1'b1; bus.id_rs_adr = 3'd3; bus.id_rs_use = 1'b1;
    bus.register_invalid[3] = 3'd2;
    #1 chk("pend2_stall", bus.stall, 1);
    tick();
    bus.register_invalid[3] = 3'd1;
    #1 chk("pend1_stall", bus.stall, 1);
    chk("pend1_state", dut.state_q, ST_STALL);
    tick();
    bus.register_invalid[3] = 3'd0;
    #1 chk("pend0_stall", bus.stall, 0);
    chk("pend0_cnt", bus.stall_cycles, 2);
    tick();
    chk("pend_noclaim", bus.regwrite_cur, 0);
    chk("pend_run", dut.state_q, ST_RUN);
    idle();

    // Load writer of r5 followed by a dependent
    bus.id_valid = 1'b1; bus.id_regwrite = 1'b1; bus.id_wr_adr = 3'd5; bus.id_is_load = 1'b1;
    #1 chk("ld_issue_stall", bus.stall, 0);
    tick();
    chk("ld_cur", bus.regwrite_cur, 1);
    chk("ld_adr", bus.regwrite_adr_id, 5);
    chk("ld_fmm", bus.from_main_mem, 1);
    bus.id_regwrite = 1'b0; bus.id_is_load = 1'b0;
    bus.id_rs_adr = 3'd5; bus.id_rs_use = 1'b1;
    #1 chk("dep_stall", bus.stall, 1);
    tick();
    chk("dep_cur_drop", bus.regwrite_cur, 0);
    chk("dep_adr_hold", bus.regwrite_adr_id, 5);
    chk("dep_fmm_hold", bus.from_main_mem, 1);
    chk("dep_release", bus.stall, 0);
    tick();
    idle();

    // Hazard plus flush
    bus.id_valid = 1'b1; bus.id_rs_adr = 3'd2; bus.id_rs_use = 1'b1;
    bus.register_invalid[2] = 3'd1;
    bus.id_regwrite = 1'b1; bus.id_wr_adr = 3'd6; bus.flush = 1'b1;
    #1 chk("flush_stall", bus.stall, 0);
    tick();
    chk("flush_cur", bus.regwrite_cur, 0);
    chk("flush_state", dut.state_q, ST_RUN);
    chk("flush_adr_hold", bus.regwrite_adr_id, 5);
    chk("flush_cnt", bus.stall_cycles, 3);
    idle();

    // 16 consecutive stalls on r1 set hang
    bus.id_valid = 1'b1; bus.id_rs_adr = 3'd1; bus.id_rs_use = 1'b1;
    bus.register_invalid[1] = 3'd3;
    repeat (15) tick();
    chk("hang_15", bus.hang, 0);
    chk("hang_state", dut.state_q, ST_STALL);
    tick();
    chk("hang_16", bus.hang, 1);
    chk("hang_cnt_sat", bus.stall_cycles, 15);
    bus.register_invalid[1] = 3'd0;
    #1 chk("hang_clear_stall", bus.stall, 0);
    tick();
    chk("hang_sticky", bus.hang, 1);
    chk("hang_run", dut.state_q, ST_RUN);
    idle();

    // Reset asserted while a claim is visible
    bus.id_valid = 1'b1; bus.id_regwrite = 1'b1; bus.id_wr_adr = 3'd7;
    tick();
    chk("mid_claim_cur", bus.regwrite_cur, 1);
    chk("mid_claim_adr", bus.regwrite_adr_id, 7);
    #2 reset = 1'b0;
    #1 chk("arst_cur", bus.regwrite_cur, 0);
    chk("arst_adr", bus.regwrite_adr_id, 0);
    chk("arst_cnt", bus.stall_cycles, 0);
    chk("arst_hang", bus.hang, 0);
    chk("arst_consec", dut.consec_q, 0);
    chk("arst_state", dut.state_q, ST_RUN);
    idle();
    tick();
    reset = 1'b1;
    #1 chk("rel_cur", bus.regwrite_cur, 0);
    tick();
    chk("rel_cur2", bus.regwrite_cur, 0);

    // Saturation of the 4-bit stall counter
    bus.id_valid = 1'b1; bus.id_rs_adr = 3'd4; bus.id_rs_use = 1'b1;
    bus.register_invalid[4] = 3'd1;
    repeat (14) tick();
    chk("sat_14", bus.stall_cycles, 14);
    repeat (6) tick();
    chk("sat_20", bus.stall_cycles, 15);
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_issue_hazard
`default_nettype wire
